reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Orders reset release for the DDR3 test design on the Mimas A7. It waits for clock lock, holds the DDR3 controller in reset for a minimum time, then releases it. After calibration completes it releases system logic. It sits beside the per-domain reset synchronizers and drives their `reset_n` inputs, so every downstream domain leaves reset in a fixed, documented order.

## Interface
- `HOLD_CYCLES`, 16: clk cycles to keep `ddr_reset_n` low after lock is seen; must be ≥1.
- `SYS_DELAY`, 8: clk cycles between calibration-done seen and `sys_reset_n` release; must be ≥1.
- `TIMEOUT_CYCLES`, 1000000: calibration watchdog length in clk cycles; used only with the macro.
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked` and `calib_done`; must be ≥2.

Ports:
- `clk`  in  1  sequencer clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `pll_locked`  in  1  MMCM/PLL lock; asynchronous to clk.
- `calib_done`  in  1  DDR3 calibration complete; asynchronous to clk.
- `soft_reset`  in  1  synchronous software reset request; level-sensitive, sampled every cycle.
- `ddr_reset_n`  out  1  DDR3 controller reset, active-low, registered.
- `sys_reset_n`  out  1  system logic reset, active-low, registered.
- `ready`  out  1  high only in RUN.
- `fault`  out  1  calibration timeout flag.
- `state`  out  3  current state encoding, for debug.

## Operation
- `pll_locked` and `calib_done` each pass through a `SYNC_STAGES` flop chain marked ASYNC_REG and reset to 0. The synchronized outputs are `lock_s` and `calib_s`.
- States and encodings: RESET=0, HOLD=1, DDR=2, SYS=3, RUN=4, FAULT=5.
- A single counter `cnt` serves all timed states. Its width is `$clog2(max(HOLD_CYCLES, SYS_DELAY, TIMEOUT_CYCLES))+1`. It clears on every state change.
- RESET: when `lock_s`=1, go to HOLD.
- HOLD: `cnt` increments each cycle. When `cnt`==`HOLD_CYCLES`-1, go to DDR.
- DDR: when `calib_s`=1, go to SYS.
- SYS: `cnt` increments each cycle. When `cnt`==`SYS_DELAY`-1, go to RUN.
- RUN: terminal while inputs stay good.
- Abort rules, evaluated in this priority order:
  1. `soft_reset`=1 in any state → RESET.
  2. `lock_s`=0 in HOLD, DDR, SYS or RUN → RESET.
  3. `calib_s`=0 in SYS or RUN → RESET.
- Output decode, registered from next-state:
  - `ddr_reset_n`=1 in DDR, SYS and RUN.
  - `sys_reset_n`=1 in RUN only.
  - `ready`=1 in RUN only.
  - `fault`=1 in FAULT only.
- Any abort forces both resets low on the same edge the state changes.

## Timing
- Reset values: `state`=RESET, `cnt`=0, synchronizers=0, `ddr_reset_n`=0, `sys_reset_n`=0, `ready`=0, `fault`=0.
- `reset_n` low mid-sequence clears everything asynchronously. No partial release remains.
- `ddr_reset_n` rises exactly `SYNC_STAGES`+1+`HOLD_CYCLES` edges after the first edge that samples `pll_locked` high. Defaults give 19.
- `sys_reset_n` and `ready` rise exactly `SYNC_STAGES`+1+`SYS_DELAY` edges after the first edge, in DDR, that samples `calib_done` high. Defaults give 11.
- Abort latency: a bad input at the pin drives the outputs low `SYNC_STAGES`+1 edges later. `soft_reset` drives them low 1 edge later.
- If `soft_reset` is held high, the block stays in RESET and the lock wait restarts on release.
- If `calib_done` is already high on entry to DDR, the block goes to SYS on the next edge.

## Configuration
- Macro: `RESET_SEQ_CALIB_TIMEOUT_EN`.
- Defined:
  - In DDR, `cnt` increments each cycle.
  - If `cnt`==`TIMEOUT_CYCLES`-1 and `calib_s`=0, go to FAULT. `ddr_reset_n` returns to 0 and `fault`=1.
  - FAULT exits only on `soft_reset` (→ RESET, `fault` cleared) or on `reset_n`. Loss of lock is ignored in FAULT.
- Undefined:
  - DDR waits indefinitely.
  - FAULT is unreachable, `fault` is tied 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- Power-up: release `reset_n` with `pll_locked`=1 and `calib_done` raised 50 cycles later → `ddr_reset_n` rises 19 edges after lock is sampled; `sys_reset_n` and `ready` rise 11 edges after calib is sampled; `state` steps 0,1,2,3,4.
- Lock drop in RUN: pulse `pll_locked` low for 5 cycles → both resets low 3 edges after the drop, `state`=0, then a full re-sequence.
- `soft_reset` for 1 cycle during HOLD, with `cnt` at 7 → RESET next edge; after release, `ddr_reset_n` rises 1+16 edges later, with the counter restarted.
- Mid-sequence reset: assert `reset_n` low in SYS → all outputs 0 immediately; `ready` never glitches high.
- With `RESET_SEQ_CALIB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, keep `calib_done`=0 → after 100 cycles in DDR, `fault`=1, `ddr_reset_n`=0 and `state`=5; `soft_reset` then returns `state` to 0 with `fault`=0.
- Without the macro, same stimulus → the block stays in DDR for 10000 cycles with `fault`=0 and `ddr_reset_n`=1.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases ddr_reset_n after PLL lock + hold time, then sys_reset_n after calibration + delay.
// Optional calibration watchdog (FAULT state) is enabled by defining RESET_SEQ_CALIB_TIMEOUT_EN.
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int SYS_DELAY      = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       calib_done,
  input  logic       soft_reset,
  output logic       ddr_reset_n,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int MAX_HS  = (HOLD_CYCLES > SYS_DELAY) ? HOLD_CYCLES : SYS_DELAY;
  localparam int MAX_ALL = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LAST  = CW'(SYS_DELAY - 1);
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
  localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_HOLD  = 3'd1,
    ST_DDR   = 3'd2,
    ST_SYS   = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] lock_sync;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] calib_sync;
  logic lock_s;
  logic calib_s;

  state_t        state_q;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ddr_nxt;
  logic          run_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync  <= '0;
      calib_sync <= '0;
    end else begin
      lock_sync  <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      calib_sync <= {calib_sync[SYNC_STAGES-2:0], calib_done};
    end
  end

  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign calib_s = calib_sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RESET: if (lock_s) state_nxt = ST_HOLD;
      ST_HOLD:  if (cnt == HOLD_LAST) state_nxt = ST_DDR;
      ST_DDR: begin
        if (calib_s) state_nxt = ST_SYS;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
        else if (cnt == TOUT_LAST) state_nxt = ST_FAULT;
`endif
      end
      ST_SYS:   if (cnt == SYS_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
      ST_FAULT: state_nxt = ST_FAULT;
`else
      ST_FAULT: state_nxt = ST_RESET;
`endif
      default:  state_nxt = ST_RESET;
    endcase

    // Aborts all land in RESET; FAULT deliberately ignores lock loss.
    if (!lock_s && (state_q inside {ST_HOLD, ST_DDR, ST_SYS, ST_RUN})) state_nxt = ST_RESET;
    if (!calib_s && (state_q inside {ST_SYS, ST_RUN}))                 state_nxt = ST_RESET;
    if (soft_reset)                                                    state_nxt = ST_RESET;

    cnt_nxt = '0;
    if (state_nxt == state_q) begin
      case (state_q)
        ST_HOLD, ST_SYS: cnt_nxt = cnt + CW'(1);
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
        ST_DDR:          cnt_nxt = cnt + CW'(1);
`endif
        default:         cnt_nxt = '0;
      endcase
    end

    ddr_nxt = state_nxt inside {ST_DDR, ST_SYS, ST_RUN};
    run_nxt = (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      cnt         <= '0;
      ddr_reset_n <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt         <= cnt_nxt;
      ddr_reset_n <= ddr_nxt;
      sys_reset_n <= run_nxt;
      ready       <= run_nxt;
    end
  end

`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
  logic fault_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= (state_nxt == ST_FAULT);
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed latency checks plus randomized pin activity against a timestamp-based model.
module tb_reset_sequencer;
  localparam int HOLD = 16;
  localparam int SYSD = 8;
  localparam int SYNC = 2;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
  localparam int TOUT  = 100;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TOUT  = 1000000;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int HMAX = 32768;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, calib_done, soft_reset;
  logic       ddr_reset_n, sys_reset_n, ready, fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES(HOLD), .SYS_DELAY(SYSD), .TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .calib_done(calib_done),
    .soft_reset(soft_reset), .ddr_reset_n(ddr_reset_n), .sys_reset_n(sys_reset_n),
    .ready(ready), .fault(fault), .state(state)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  // Reference model: state from the spec's encoding, timers as "edges since entry".
  int m_state;
  int m_entry;
  int rst_edge;
  bit lk_hist[HMAX];
  bit cl_hist[HMAX];

  bit watch_rdy = 1'b0;
  int rdy_glitch = 0;
  always @(posedge ready) if (watch_rdy) rdy_glitch++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [6:0] dut_vec();
    return {state, ddr_reset_n, sys_reset_n, ready, fault};
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [2:0] s;
    logic d, r, f;
    s = 3'(m_state);
    d = (m_state == 2) || (m_state == 3) || (m_state == 4);
    r = (m_state == 4);
    f = (m_state == 5);
    return {s, d, r, r, f};
  endfunction

  function automatic logic out_bit(input int which);
    case (which)
      0:       return ddr_reset_n;
      1:       return sys_reset_n;
      2:       return ready;
      default: return fault;
    endcase
  endfunction

  task automatic m_reset();
    m_state  = 0;
    m_entry  = edge_n;
    rst_edge = edge_n;
  endtask

  task automatic m_edge();
    bit ls, cs;
    int nxt, el, idx;
    idx = edge_n - SYNC;
    ls  = (idx > rst_edge) ? lk_hist[idx] : 1'b0;
    cs  = (idx > rst_edge) ? cl_hist[idx] : 1'b0;
    el  = edge_n - m_entry;
    nxt = m_state;
    case (m_state)
      0: if (ls) nxt = 1;
      1: if (el == HOLD) nxt = 2;
      2: if (cs) nxt = 3; else if (TO_EN && el == TOUT) nxt = 5;
      3: if (el == SYSD) nxt = 4;
      default: ;
    endcase
    if (!ls && m_state >= 1 && m_state <= 4) nxt = 0;
    if (!cs && (m_state == 3 || m_state == 4)) nxt = 0;
    if (soft_reset) nxt = 0;
    if (nxt != m_state) m_entry = edge_n;
    m_state = nxt;
    lk_hist[edge_n] = pll_locked;
    cl_hist[edge_n] = calib_done;
  endtask

  // Called aligned to a negedge; returns aligned to the next negedge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    if (edge_n >= HMAX) begin
      $display("FAIL edge_budget: got=%0d exp<%0d", edge_n, HMAX);
      $fatal(1, "edge budget exceeded");
    end
    if (!reset_n) m_reset(); else m_edge();
    #1;
    chk("cyc", 32'(dut_vec()), 32'(exp_vec()));
    @(negedge clk);
  endtask

  task automatic wait_lvl(input int which, input logic lvl, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (out_bit(which) === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 chk("arst_now", 32'(dut_vec()), 32'd0);
    m_reset();
    step();
  endtask

  initial begin
    int n;
    reset_n = 1'b0; pll_locked = 1'b0; calib_done = 1'b0; soft_reset = 1'b0;
    m_reset();
    @(negedge clk);
    step();
    step();
    chk("reset_state", 32'(dut_vec()), 32'd0);

    // Power-up with lock already present.
    reset_n = 1'b1; pll_locked = 1'b1;
    wait_lvl(0, 1'b1, 60, n);
    chk("lock_to_ddr", n, SYNC + 1 + HOLD);
    for (int i = 0; i < 49; i++) step();
    chk("ddr_wait_state", 32'(state), 32'd2);
    calib_done = 1'b1;
    wait_lvl(1, 1'b1, 40, n);
    chk("calib_to_sys", n, SYNC + 1 + SYSD);
    chk("ready_run", 32'(ready), 32'd1);
    chk("state_run", 32'(state), 32'd4);

    // Lock drop in RUN for 5 cycles, then full re-sequence.
    pll_locked = 1'b0;
    wait_lvl(0, 1'b0, 10, n);
    chk("lock_drop_lat", n, SYNC + 1);
    chk("lock_drop_state", 32'(state), 32'd0);
    chk("lock_drop_sys", 32'(sys_reset_n), 32'd0);
    step(); step();
    pll_locked = 1'b1;
    wait_lvl(0, 1'b1, 60, n);
    chk("relock_to_ddr", n, SYNC + 1 + HOLD);
    wait_lvl(2, 1'b1, 40, n);
    chk("resync_ready", n, 1 + SYSD);

    // Soft reset during HOLD with the counter at 7.
    async_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("hold_state", 32'(state), 32'd1);
    soft_reset = 1'b1;
    step();
    chk("soft_state", 32'(state), 32'd0);
    chk("soft_ddr", 32'(ddr_reset_n), 32'd0);
    soft_reset = 1'b0;
    wait_lvl(0, 1'b1, 60, n);
    chk("soft_to_ddr", n, 1 + HOLD);

    // Mid-sequence asynchronous reset while in SYS.
    watch_rdy = 1'b1;
    step();
    chk("sys_state", 32'(state), 32'd3);
    async_reset();
    chk("no_rdy_glitch", rdy_glitch, 0);
    watch_rdy = 1'b0;
    calib_done = 1'b0;
    reset_n = 1'b1;

    // Calibration never completes.
    wait_lvl(0, 1'b1, 60, n);
    chk("to_ddr_nocal", n, SYNC + 1 + HOLD);
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
    wait_lvl(3, 1'b1, 2 * TOUT, n);
    chk("timeout_lat", n, TOUT);
    chk("timeout_ddr", 32'(ddr_reset_n), 32'd0);
    chk("timeout_state", 32'(state), 32'd5);
    pll_locked = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("fault_sticky", 32'(state), 32'd5);
    soft_reset = 1'b1;
    step();
    chk("fault_clr_state", 32'(state), 32'd0);
    chk("fault_clr_flag", 32'(fault), 32'd0);
    soft_reset = 1'b0;
    pll_locked = 1'b1;
`else
    for (int i = 0; i < 10000; i++) step();
    chk("nocal_state", 32'(state), 32'd2);
    chk("nocal_fault", 32'(fault), 32'd0);
    chk("nocal_ddr", 32'(ddr_reset_n), 32'd1);
`endif

    // Randomized pin activity.
    for (int c = 0; c < 3000; c++) begin
      pll_locked = ($urandom_range(0, 99) >= 2);
      if (calib_done) calib_done = ($urandom_range(0, 99) != 0);
      else            calib_done = ($urandom_range(0, 99) < 5);
      soft_reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
